// File: rtl/spi_reg_bank.sv
// SPI mode-0 configuration register bank; every SPI pin is oversampled in the clk domain.
// Define SPI_REG_READBACK_EN to build the CIPO readback path; without it cipo/cipo_oe are tied low.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);
    // state | meaning
    // IDLE  | ncs high (or held low since reset), SCLK ignored
    // ADDR  | receiving R/W bit and address bits
    // DATA  | receiving data bits
    // DONE  | exactly FRAME_LEN bits received, commit allowed on ncs rise
    // OVER  | more than FRAME_LEN bits received, frame is discarded

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_OVER} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, cnt_nxt;
    logic [FRAME_LEN-1:0] shift_q, shift_nxt;
    logic                 shift_en;

    logic [2:0] ncs_sr, sclk_sr, copi_sr;
    logic       ncs_fall, ncs_rise, sclk_rise, copi_s;

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              commit;

    // Chains reset low so that ncs already low at reset release produces no falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sr  <= '0;
            sclk_sr <= '0;
            copi_sr <= '0;
        end else begin
            ncs_sr  <= {ncs_sr[1:0], ncs};
            sclk_sr <= {sclk_sr[1:0], sclk};
            copi_sr <= {copi_sr[1:0], copi};
        end
    end

    assign ncs_fall  =  ncs_sr[2] & ~ncs_sr[1];
    assign ncs_rise  = ~ncs_sr[2] &  ncs_sr[1];
    assign sclk_rise = ~sclk_sr[2] & sclk_sr[1];
    assign copi_s    =  copi_sr[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            shift_q <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_nxt = shift_q;
        shift_en  = 1'b0;
        if (ncs_fall) begin
            state_nxt = S_ADDR;
            cnt_nxt   = '0;
        end else if (ncs_rise) begin
            state_nxt = S_IDLE;
        end else if (state != S_IDLE && sclk_rise) begin
            shift_en  = 1'b1;
            shift_nxt = {shift_q[FRAME_LEN-2:0], copi_s};
            if (bit_cnt != CNT_W'(FRAME_LEN + 1))
                cnt_nxt = bit_cnt + 1'b1;
            if (cnt_nxt > CNT_W'(FRAME_LEN))
                state_nxt = S_OVER;
            else if (cnt_nxt == CNT_W'(FRAME_LEN))
                state_nxt = S_DONE;
            else if (cnt_nxt >= CNT_W'(1 + ADDR_W))
                state_nxt = S_DATA;
            else
                state_nxt = S_ADDR;
        end
    end

    assign frame_addr = shift_q[DATA_W +: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign commit     = ncs_rise && (state == S_DONE) && shift_q[FRAME_LEN-1]
                        && (frame_addr < ADDR_W'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                reg_q[i] <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit)
                wr_addr <= frame_addr;
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && frame_addr == ADDR_W'(i))
                    reg_q[i] <= frame_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = reg_q[g];
    end

`ifdef SPI_REG_READBACK_EN
    logic              sclk_fall;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] sout_q;
    logic              rd_active;
    logic              cipo_q;

    assign sclk_fall = sclk_sr[2] & ~sclk_sr[1];
    assign rd_addr   = shift_nxt[ADDR_W-1:0];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == ADDR_W'(i))
                rd_data = reg_q[i];
    end

    // Load happens on the rising edge that completes the address; data leaves on falling edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sout_q    <= '0;
            rd_active <= 1'b0;
            cipo_q    <= 1'b0;
        end else if (ncs_fall || ncs_rise) begin
            rd_active <= 1'b0;
            cipo_q    <= 1'b0;
        end else if (shift_en && cnt_nxt == CNT_W'(1 + ADDR_W)) begin
            sout_q    <= rd_data;
            rd_active <= ~shift_nxt[ADDR_W];
        end else if (rd_active && sclk_fall && state == S_DATA) begin
            cipo_q <= sout_q[DATA_W-1];
            sout_q <= {sout_q[DATA_W-2:0], 1'b0};
        end else if (state != S_DATA) begin
            cipo_q <= 1'b0;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = ~ncs_sr[2] & (state != S_IDLE);
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboarded bench for spi_reg_bank: commit expectations are queued per frame and
// retired when wr_strobe fires; register contents are also checked after every frame.
module tb_spi_reg_bank;
    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int HALF     = 5;
`ifdef SPI_REG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       ncs = 1'b1;
    logic                       sclk = 1'b0;
    logic                       copi = 1'b0;
    logic                       cipo, cipo_oe, wr_strobe;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic [ADDR_W-1:0]          wr_addr;

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]          addr;
        logic [NUM_REGS*DATA_W-1:0] regs;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [ADDR_W-1:0] m_addr;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++)
            f[i*DATA_W +: DATA_W] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++)
            m_regs[i] = '0;
        m_addr = '0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            if (sb_q.size() == 0) begin
                chk("spurious_strobe", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", wr_addr, mon_e.addr);
                chk("regs_at_strobe", regs, mon_e.regs);
            end
        end
    end

    // al holds the frame left-aligned: al[31] is the first bit sent.
    task automatic end_frame(input logic [31:0] al, input int n, input bit valid);
        logic [ADDR_W-1:0] a;
        a = al[30:24];
        if (valid && n == 16 && al[31] && a < NUM_REGS) begin
            m_regs[a] = al[23:16];
            m_addr    = a;
            sb_q.push_back('{m_addr, flat()});
        end
        ncs = 1'b1;
        wait_clk(10);
        chk("strobe_pending", sb_q.size(), 0);
        chk("regs", regs, flat());
        chk("wr_addr_hold", wr_addr, m_addr);
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit raise);
        logic [31:0]       al;
        logic [DATA_W-1:0] rd_val;
        logic [ADDR_W-1:0] a;
        bit                is_read;
        logic              exp_cipo;
        al      = bits << (32 - n);
        a       = al[30:24];
        is_read = (n >= 1 + ADDR_W) && !al[31];
        rd_val  = (a < NUM_REGS) ? m_regs[a] : '0;
        ncs = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < n; k++) begin
            copi = al[31-k];
            wait_clk(HALF);
            if (k >= 1 && k < 16) begin
                exp_cipo = 1'b0;
                if (RB && is_read && k >= 8)
                    exp_cipo = rd_val[15-k];
                chk("cipo", cipo, exp_cipo);
            end
            if (k == 4)
                chk("cipo_oe", cipo_oe, RB);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        if (raise)
            end_frame(al, n, 1'b1);
    endtask

    initial begin
        model_reset();
        // T1 reset
        wait_clk(2);
        chk("rst_regs", regs, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_cipo", cipo, 0);
        chk("rst_cipo_oe", cipo_oe, 0);
        rst = 1'b0;
        wait_clk(4);
        chk("post_rst_regs", regs, 0);
        chk("post_rst_oe", cipo_oe, 0);
        chk("post_rst_waddr", wr_addr, 0);

        // T2 writes
        send(32'h82A5, 16, 1'b1);
        send(32'h8011, 16, 1'b1);
        // T3 out-of-range addresses
        send(32'h8533, 16, 1'b1);
        send(32'hFF33, 16, 1'b1);
        // T4 framing: short, long, exact
        send(32'h8166 >> 1, 15, 1'b1);
        send({15'd0, 16'h8166, 1'b1}, 17, 1'b1);
        send(32'h8166, 16, 1'b1);
        // T5 read of reg2
        send(32'h0200, 16, 1'b1);

        // T6 reset mid-frame, ncs still low across reset
        send(32'h83C3 >> 6, 10, 1'b0);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        model_reset();
        wait_clk(4);
        chk("midframe_rst_regs", regs, 0);
        end_frame((32'h83C3 >> 6) << 22, 10, 1'b0);
        send(32'h83C3, 16, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
